cp0_irq_unit: RTL and testbench

Parametrised coprocessor-0 exception/interrupt unit for the pipelined MIPS core. It sits beside the M stage and holds SR, Cause, EPC and PRId. It arbitrates the instruction's exception code against up to `HW_IRQ_N` hardware interrupt lines and raises a single-cycle request that flushes the pipe and redirects fetch to the handler. Compared with the previous fixed 6-line CP0, the line count, handler vector and PRId are parameters, and input synchronisation is optional.

---
 rtl/cp0_irq_unit.sv | 156 +++++++++++++++
 tb/tb_cp0_irq_unit.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_irq_unit.sv
// cp0_irq_unit: coprocessor-0 exception/interrupt unit beside the M stage.
// Holds SR (12), Cause (13), EPC (14) and PRId (15), arbitrates the M-stage
// exception code against HW_IRQ_N level interrupt lines and raises a
// single-cycle redirect request towards EXC_VECTOR.
// Optional build macro: CP0_IRQ_SYNC_EN adds a 2-flop synchroniser per line.
module cp0_irq_unit #(
    parameter int unsigned HW_IRQ_N   = 6,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter logic [31:0] PRID       = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                we,
    input  logic [4:0]          addr,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata,
    input  logic [31:0]         pc,
    input  logic                bd,
    input  logic [4:0]          exc_code,
    input  logic [HW_IRQ_N-1:0] hw_int,
    input  logic                eret,
    output logic                req,
    output logic [31:0]         vector,
    output logic [31:0]         epc
);

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    // SR fields
    logic [HW_IRQ_N-1:0] sr_im;
    logic                sr_exl;
    logic                sr_ie;

    // Cause fields
    logic                cause_bd;
    logic [HW_IRQ_N-1:0] cause_ip;
    logic [4:0]          cause_exc;

    logic [31:0]         epc_q;

    logic [HW_IRQ_N-1:0] irq_eff;
    logic                int_req;
    logic                exc_req;
    logic [31:0]         epc_next;
    logic [31:0]         sr_val;
    logic [31:0]         cause_val;

`ifdef CP0_IRQ_SYNC_EN
    logic [HW_IRQ_N-1:0] sync_q1;
    logic [HW_IRQ_N-1:0] sync_q2;

    // Two-flop synchroniser per interrupt line
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= hw_int;
            sync_q2 <= sync_q1;
        end
    end

    assign irq_eff = sync_q2;
`else
    assign irq_eff = hw_int;
`endif

    // Request arbitration; gated by reset_n so nothing is requested while
    // reset is held, even if exc_code is nonzero.
    assign int_req = reset_n & (|(irq_eff & sr_im)) & sr_ie & ~sr_exl;
    assign exc_req = reset_n & (exc_code != 5'd0) & ~sr_exl;
    assign req     = int_req | exc_req;
    assign vector  = req ? EXC_VECTOR : 32'h0000_0000;
    assign epc     = epc_q;

    // EPC capture target: delay-slot instructions restart at the branch
    always_comb begin
        epc_next = bd ? (pc - 32'd4) : pc;
        epc_next[1:0] = 2'b00;
    end

    // SR update: request sets EXL and discards mtc0; else eret, then mtc0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_im  <= '0;
            sr_exl <= 1'b0;
            sr_ie  <= 1'b0;
        end else if (req) begin
            sr_exl <= 1'b1;
        end else begin
            if (eret) begin
                sr_exl <= 1'b0;
            end
            if (we && (addr == REG_SR)) begin
                sr_im  <= wdata[10 +: HW_IRQ_N];
                sr_exl <= wdata[1];
                sr_ie  <= wdata[0];
            end
        end
    end

    // Cause update: IP tracks the lines every cycle, BD/ExcCode on request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= 5'd0;
        end else begin
            cause_ip <= irq_eff;
            if (req) begin
                cause_bd  <= bd;
                cause_exc <= int_req ? 5'd0 : exc_code;
            end
        end
    end

    // EPC update: request capture has priority over an mtc0 write
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            epc_q <= '0;
        end else if (req) begin
            epc_q <= epc_next;
        end else if (we && (addr == REG_EPC)) begin
            epc_q <= {wdata[31:2], 2'b00};
        end
    end

    // Assemble the readable register images
    always_comb begin
        sr_val = '0;
        sr_val[10 +: HW_IRQ_N] = sr_im;
        sr_val[1] = sr_exl;
        sr_val[0] = sr_ie;

        cause_val = '0;
        cause_val[31] = cause_bd;
        cause_val[10 +: HW_IRQ_N] = cause_ip;
        cause_val[6:2] = cause_exc;
    end

    // mfc0 read mux, showing pre-edge contents
    always_comb begin
        rdata = '0;
        case (addr)
            REG_SR:    rdata = sr_val;
            REG_CAUSE: rdata = cause_val;
            REG_EPC:   rdata = epc_q;
            REG_PRID:  rdata = PRID;
            default:   rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_irq_unit.sv
// Self-checking bench for cp0_irq_unit: expected values are queued when the
// stimulus is driven and compared against sampled DUT outputs per scenario.
module tb_cp0_irq_unit;

    localparam logic [31:0] T_PRID = 32'h1234_5678;
    localparam logic [31:0] T_VEC  = 32'h0000_4180;
`ifdef CP0_IRQ_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  exc_code;
    logic [5:0]  hw_int;
    logic        eret;
    logic        req;
    logic [31:0] vector;
    logic [31:0] epc;

    cp0_irq_unit #(
        .HW_IRQ_N  (6),
        .EXC_VECTOR(T_VEC),
        .PRID      (T_PRID)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .pc      (pc),
        .bd      (bd),
        .exc_code(exc_code),
        .hw_int  (hw_int),
        .eret    (eret),
        .req     (req),
        .vector  (vector),
        .epc     (epc)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] got[$];
    int          n_checks = 0;
    int          n_err = 0;

    task automatic want(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic rd(input logic [4:0] a);
        addr = a;
        #1;
        got.push_back(rdata);
    endtask

    task automatic idle();
        we = 1'b0; addr = 5'd0; wdata = '0; pc = '0;
        bd = 1'b0; exc_code = 5'd0; eret = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        hw_int = '0;
        reset_n = 1'b1;
        @(negedge clk);
        reset_n = 1'b0;
        exc_code = 5'd5;
        want("rst_req", 32'd0); want("rst_vector", 32'd0); want("rst_epc", 32'd0);
        want("rst_sr", 32'd0); want("rst_cause", 32'd0); want("rst_epc_reg", 32'd0);
        want("rst_prid", T_PRID);
        #1;
        got.push_back({31'd0, req}); got.push_back(vector); got.push_back(epc);
        rd(5'd12); rd(5'd13); rd(5'd14); rd(5'd15);
        @(negedge clk);
        reset_n = 1'b1;
        idle();
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            logic [31:0] o = (got.size() > 0) ? got.pop_front() : 'x;
            n_checks++;
            if (o !== e.val) begin
                n_err++;
                $display("FAIL %s: got %h, expected %h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic test_overflow_bd();
        @(negedge clk);
        exc_code = 5'd12; pc = 32'h3008; bd = 1'b1;
        want("ovf_req", 32'd1); want("ovf_vector", T_VEC);
        #1;
        got.push_back({31'd0, req}); got.push_back(vector);
        @(negedge clk);
        idle();
        want("ovf_req_after", 32'd0); want("ovf_vector_after", 32'd0);
        want("ovf_epc_out", 32'h3004);
        want("ovf_epc", 32'h3004); want("ovf_cause", 32'h8000_0030); want("ovf_sr", 32'h0000_0002);
        #1;
        got.push_back({31'd0, req}); got.push_back(vector); got.push_back(epc);
        rd(5'd14); rd(5'd13); rd(5'd12);
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            logic [31:0] o = (got.size() > 0) ? got.pop_front() : 'x;
            n_checks++;
            if (o !== e.val) begin
                n_err++;
                $display("FAIL %s: got %h, expected %h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic test_masking();
        @(negedge clk);
        exc_code = 5'd10; pc = 32'h5000;
        want("mask_req", 32'd0); want("mask_vector", 32'd0);
        #1;
        got.push_back({31'd0, req}); got.push_back(vector);
        @(negedge clk);
        idle();
        want("mask_epc", 32'h3004); want("mask_cause", 32'h8000_0030);
        rd(5'd14); rd(5'd13);
        @(negedge clk);
        eret = 1'b1; pc = 32'h9000;
        want("eret_req", 32'd0);
        #1;
        got.push_back({31'd0, req});
        @(negedge clk);
        idle();
        want("eret_sr", 32'd0);
        rd(5'd12);
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            logic [31:0] o = (got.size() > 0) ? got.pop_front() : 'x;
            n_checks++;
            if (o !== e.val) begin
                n_err++;
                $display("FAIL %s: got %h, expected %h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic test_irq_vs_exc();
        @(negedge clk);
        we = 1'b1; addr = 5'd12; wdata = 32'h0000_0401;
        want("sr_same_cycle_old", 32'd0);
        #1;
        got.push_back(rdata);
        @(negedge clk);
        idle();
        want("sr_written", 32'h0000_0401);
        rd(5'd12);
        for (int i = 0; i < SYNC_LAT; i++) begin
            @(negedge clk);
            idle();
            hw_int = 6'b000001;
            want("irq_sync_lag_req", 32'd0);
            #1;
            got.push_back({31'd0, req});
        end
        @(negedge clk);
        hw_int = 6'b000001; exc_code = 5'd4; pc = 32'h6000; addr = 5'd13;
        want("irq_req", 32'd1); want("irq_vector", T_VEC); want("irq_ip_not_yet", 32'h8000_0030);
        #1;
        got.push_back({31'd0, req}); got.push_back(vector); got.push_back(rdata);
        @(negedge clk);
        idle();
        want("irq_cause", 32'h0000_0400); want("irq_epc", 32'h6000); want("irq_sr", 32'h0000_0403);
        rd(5'd13); rd(5'd14); rd(5'd12);
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            logic [31:0] o = (got.size() > 0) ? got.pop_front() : 'x;
            n_checks++;
            if (o !== e.val) begin
                n_err++;
                $display("FAIL %s: got %h, expected %h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic test_eret_collide();
        @(negedge clk);
        idle();
        hw_int = '0;
        repeat (SYNC_LAT) @(negedge clk);
        @(negedge clk);
        we = 1'b1; addr = 5'd12; wdata = 32'h0000_0401;
        want("clr_exl_req", 32'd0);
        #1;
        got.push_back({31'd0, req});
        for (int i = 0; i < SYNC_LAT; i++) begin
            @(negedge clk);
            idle();
            hw_int = 6'b000001;
            want("collide_lag_req", 32'd0);
            #1;
            got.push_back({31'd0, req});
        end
        @(negedge clk);
        idle();
        hw_int = 6'b000001; eret = 1'b1; pc = 32'h4200;
        want("collide_req", 32'd1);
        #1;
        got.push_back({31'd0, req});
        @(negedge clk);
        idle();
        want("collide_epc_out", 32'h4200); want("collide_epc", 32'h4200); want("collide_sr", 32'h0000_0403);
        #1;
        got.push_back(epc);
        rd(5'd14); rd(5'd12);
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            logic [31:0] o = (got.size() > 0) ? got.pop_front() : 'x;
            n_checks++;
            if (o !== e.val) begin
                n_err++;
                $display("FAIL %s: got %h, expected %h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic test_mtc0();
        @(negedge clk);
        idle();
        hw_int = '0;
        repeat (SYNC_LAT) @(negedge clk);
        @(negedge clk);
        we = 1'b1; addr = 5'd12; wdata = 32'h0;
        @(negedge clk);
        we = 1'b1; addr = 5'd14; wdata = 32'h3003;
        want("epc_same_cycle_old", 32'h4200);
        #1;
        got.push_back(rdata);
        @(negedge clk);
        idle();
        want("epc_write", 32'h3000); want("epc_write_out", 32'h3000); want("unmapped_read", 32'd0);
        rd(5'd14);
        got.push_back(epc);
        rd(5'd3);
        @(negedge clk);
        we = 1'b1; addr = 5'd13; wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        idle();
        want("cause_ro", 32'd0);
        rd(5'd13);
        @(negedge clk);
        we = 1'b1; addr = 5'd12; wdata = 32'h0000_0401; exc_code = 5'd8; pc = 32'h7000;
        want("mtc0_req", 32'd1);
        #1;
        got.push_back({31'd0, req});
        @(negedge clk);
        idle();
        want("mtc0_discard_sr", 32'h0000_0002); want("mtc0_req_epc", 32'h7000); want("mtc0_req_cause", 32'h0000_0020);
        rd(5'd12); rd(5'd14); rd(5'd13);
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            logic [31:0] o = (got.size() > 0) ? got.pop_front() : 'x;
            n_checks++;
            if (o !== e.val) begin
                n_err++;
                $display("FAIL %s: got %h, expected %h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic test_reset_mid_exc();
        @(negedge clk);
        exc_code = 5'd3; pc = 32'h8000;
        reset_n = 1'b0;
        want("midrst_req", 32'd0); want("midrst_vector", 32'd0); want("midrst_epc", 32'd0);
        want("midrst_sr", 32'd0);
        #1;
        got.push_back({31'd0, req}); got.push_back(vector); got.push_back(epc);
        rd(5'd12);
        @(negedge clk);
        reset_n = 1'b1;
        idle();
        @(negedge clk);
        want("postrst_sr", 32'd0); want("postrst_epc", 32'd0);
        rd(5'd12); rd(5'd14);
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            logic [31:0] o = (got.size() > 0) ? got.pop_front() : 'x;
            n_checks++;
            if (o !== e.val) begin
                n_err++;
                $display("FAIL %s: got %h, expected %h", e.tag, o, e.val);
            end
        end
    endtask

    initial begin
        test_reset();
        test_overflow_bd();
        test_masking();
        test_irq_vs_exc();
        test_eret_collide();
        test_mtc0();
        test_reset_mid_exc();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
